mul_rr_scheduler: RTL
=====================

MUL_RR_SCHEDULER -- requirements
Module: mul_rr_scheduler

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters sharing one multiplier.
REQ-002 SHALL have parameter TIMEOUT, default 40: maximum cycles spent waiting for mul_done.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  in  NREQ  per-requester operation request.
REQ-006 SHALL have port req_ready  out  NREQ  one-hot acceptance strobe.
REQ-007 SHALL have port req_a  in  NREQ*32  packed multipliers; requester i occupies [32i+31:32i].
REQ-008 SHALL have port req_b  in  NREQ*32  packed multiplicands, same packing.
REQ-009 SHALL have port rsp_valid  out  1  result available.
REQ-010 SHALL have port rsp_ready  in  1  consumer accepts result.
REQ-011 SHALL have port rsp_id  out  clog2(NREQ)  index of the requester owning the result.
REQ-012 SHALL have port rsp_result  out  64  signed product.
REQ-013 SHALL have port rsp_err  out  1  result invalid due to timeout.
REQ-014 SHALL have ports mul_start (out 1), mul_a (out 32), mul_b (out 32): the shared multiplier command.
REQ-015 SHALL have ports mul_done (in 1) and mul_result (in 64): the shared multiplier completion.
REQ-016 SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-017 SHALL implement states IDLE, ISSUE, WAIT, RESP.
REQ-018 In IDLE with any req_valid high, SHALL assert req_ready for exactly one requester, chosen round-robin starting at last_grant+1 (mod NREQ).
REQ-019 On that req_ready cycle, SHALL latch the granted requester's operands and index, then go to ISSUE.
REQ-020 req_ready SHALL be zero in all states other than IDLE.
REQ-021 ISSUE SHALL pulse mul_start for exactly one cycle and then go to WAIT.
REQ-022 mul_a/mul_b SHALL be driven from the latched operands and stay stable from ISSUE until leaving WAIT.
REQ-023 WAIT SHALL run a cycle counter cleared on entry.
REQ-024 On mul_done in WAIT, SHALL capture mul_result with rsp_err=0 and go to RESP.
REQ-025 If the counter reaches TIMEOUT with no mul_done, SHALL load rsp_result=0 with rsp_err=1 and go to RESP.
REQ-026 If mul_done and timeout occur in the same cycle, mul_done SHALL win.
REQ-027 mul_done outside WAIT SHALL be ignored.
REQ-028 RESP SHALL hold rsp_valid, rsp_id, rsp_result and rsp_err stable until rsp_ready is sampled high.
REQ-029 On the RESP handshake, SHALL update last_grant to the served index and return to IDLE.
REQ-030 Latency: acceptance at cycle N, mul_start at N+1, rsp_valid the cycle after mul_done.
REQ-031 Throughput: minimum 4 cycles per operation plus multiplier latency; no overlap between operations.

Reset
REQ-032 Asserting reset (low) SHALL immediately force state IDLE and last_grant=NREQ-1, so requester 0 wins first after reset.
REQ-033 Asserting reset SHALL immediately force all outputs and the counter to 0, even mid-operation.
REQ-034 After reset, the in-flight operation SHALL be discarded with no response.

Structure
REQ-035 Package mul_sched_pkg SHALL hold the state enum and the constants OP_W=32, RES_W=64.
REQ-036 Round-robin selection SHALL be a sub-module rr_arbiter: inputs are the request vector and last_grant; outputs are the one-hot grant and its index.

Verification
REQ-037 Scenario 1: requester 1 sends a=3, b=-2; the multiplier model returns done 33 cycles after start -> exactly one mul_start pulse, rsp_id=1, rsp_result=0xFFFFFFFFFFFFFFFA, rsp_err=0.
REQ-038 Scenario 2: all 4 req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0.
REQ-039 Scenario 3: rsp_ready held low for 10 cycles -> rsp_* remain stable and no req_ready is asserted during the stall.
REQ-040 Scenario 4: mul_done never asserted with TIMEOUT=40 -> RESP entered after 40 WAIT cycles with rsp_err=1 and rsp_result=0.
REQ-041 Scenario 5: reset pulled low mid-WAIT -> all outputs 0 without waiting for a clk edge; after release, with requesters 0 and 2 both valid, requester 0 is granted.
REQ-042 Scenario 6: mul_done arrives in the final timeout cycle -> rsp_err=0 and the product is returned.

Source files
------------

// File: rtl/mul_sched_pkg.sv
// Shared types and widths for the round-robin multiplier scheduler.
package mul_sched_pkg;

    localparam int OP_W  = 32;
    localparam int RES_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester selection: search starts one past the last served index.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last_grant,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx
);

    logic           found;
    logic [IDW-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = IDW'((32'(last_grant) + k) % NREQ);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/mul_rr_scheduler.sv
// Shares one external multiplier among NREQ requesters, one operation at a time,
// with round-robin acceptance and a bounded wait for the multiplier result.
module mul_rr_scheduler
    import mul_sched_pkg::*;
#(
    parameter  int NREQ    = 4,
    parameter  int TIMEOUT = 40,
    localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*OP_W-1:0] req_a,
    input  logic [NREQ*OP_W-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [RES_W-1:0]     rsp_result,
    output logic                 rsp_err,
    output logic                 mul_start,
    output logic [OP_W-1:0]      mul_a,
    output logic [OP_W-1:0]      mul_b,
    input  logic                 mul_done,
    input  logic [RES_W-1:0]     mul_result,
    output logic                 busy
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t          state, state_next;
    logic [IDW-1:0]  last_grant, id_q, gnt_idx;
    logic [NREQ-1:0] gnt;
    logic [OP_W-1:0] a_q, b_q, sel_a, sel_b;
    logic [CW-1:0]   cnt;
    logic [RES_W-1:0] res_q;
    logic            err_q;
    logic            accept, timeout;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (gnt),
        .grant_idx  (gnt_idx)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_idx == IDW'(i)) begin
                sel_a = req_a[i*OP_W +: OP_W];
                sel_b = req_b[i*OP_W +: OP_W];
            end
        end
    end

    // Last WAIT cycle is the one where the counter shows TIMEOUT-1.
    assign timeout = (cnt == CW'(TIMEOUT - 1));

    always_comb begin
        state_next = state;
        req_ready  = '0;
        mul_start  = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    // Gated by reset so the strobe drops immediately while reset is held.
                    req_ready  = reset ? gnt : '0;
                    accept     = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                mul_start  = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (mul_done || timeout) state_next = RESP;
            end
            RESP: begin
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= IDW'(NREQ - 1);
            id_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            cnt        <= '0;
            res_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        id_q <= gnt_idx;
                        a_q  <= sel_a;
                        b_q  <= sel_b;
                    end
                end
                ISSUE: cnt <= '0;
                WAIT: begin
                    cnt <= cnt + CW'(1);
                    if (mul_done) begin
                        res_q <= mul_result;
                        err_q <= 1'b0;
                    end else if (timeout) begin
                        res_q <= '0;
                        err_q <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) last_grant <= id_q;
                end
                default: ;
            endcase
        end
    end

    assign mul_a      = a_q;
    assign mul_b      = b_q;
    assign rsp_id     = id_q;
    assign rsp_result = res_q;
    assign rsp_err    = err_q;
    assign rsp_valid  = (state == RESP);
    assign busy       = (state != IDLE);

endmodule
